// File: rtl/apb_share_arbiter.sv
// apb_share_arbiter
//   Shares one APB segment between two masters (m0 = CPU side, m1 = DMA/debug).
//   Each master holds req with stable addr/write/wdata until its one-cycle done
//   pulse. Contested requests are granted round-robin. The block runs a
//   two-phase APB transfer with slave wait states and aborts a transfer that
//   waits TIMEOUT ACCESS cycles without pready (TIMEOUT = 0 disables this).
//
// Ports
//   apb_pclk, apb_prstn         clock, async active-low reset
//   mN_req/addr/write/wdata     requester N transfer request (N = 0, 1)
//   mN_gnt                      high from SETUP through RECOVER for the winner
//   mN_done/err                 completion pulse and error flag (pslverr or timeout)
//   mN_rdata                    read data, updated only on read completions
//   apb_*                       APB master side
//   timeout_evt                 one-cycle pulse when a transfer is aborted
//
// Every output is a flop; next values are computed in one combinational block.

module apb_share_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              apb_pclk,
    input  logic              apb_prstn,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              apb_psel,
    output logic              apb_penable,
    output logic              apb_pwrite,
    output logic [ADDR_W-1:0] apb_paddr,
    output logic [DATA_W-1:0] apb_pwdata,
    input  logic [DATA_W-1:0] apb_prdata,
    input  logic              apb_pready,
    input  logic              apb_pslverr,
    output logic              timeout_evt
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    // Count value seen in the last ACCESS cycle allowed before the abort.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    logic [1:0]              req;
    logic [1:0][ADDR_W-1:0]  m_addr;
    logic [1:0]              m_write;
    logic [1:0][DATA_W-1:0]  m_wdata;
    logic                    pick;

    state_t                  state, state_nxt;
    logic                    last, last_nxt;
    logic                    win, win_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    psel_q, psel_nxt;
    logic                    pen_q, pen_nxt;
    logic                    pwrite_q, pwrite_nxt;
    logic [ADDR_W-1:0]       paddr_q, paddr_nxt;
    logic [DATA_W-1:0]       pwdata_q, pwdata_nxt;
    logic [1:0]              gnt_q, gnt_nxt;
    logic [1:0]              done_q, done_nxt;
    logic [1:0]              err_q, err_nxt;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_nxt;
    logic                    tmo_q, tmo_nxt;
    logic                    fin, fin_err, fin_tmo;
    logic                    tmo_hit;

    assign req     = {m1_req, m0_req};
    assign m_addr  = {m1_addr, m0_addr};
    assign m_write = {m1_write, m0_write};
    assign m_wdata = {m1_wdata, m0_wdata};

    // Lone requester wins outright; a contest goes to the one not served last.
    assign pick    = (req[0] & req[1]) ? ~last : req[1];
    assign tmo_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_comb begin
        state_nxt  = state;
        last_nxt   = last;
        win_nxt    = win;
        cnt_nxt    = cnt;
        psel_nxt   = psel_q;
        pen_nxt    = pen_q;
        pwrite_nxt = pwrite_q;
        paddr_nxt  = paddr_q;
        pwdata_nxt = pwdata_q;
        gnt_nxt    = gnt_q;
        done_nxt   = '0;
        err_nxt    = err_q;
        rdata_nxt  = rdata_q;
        tmo_nxt    = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        fin_tmo    = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    win_nxt      = pick;
                    last_nxt     = pick;
                    paddr_nxt    = m_addr[pick];
                    pwrite_nxt   = m_write[pick];
                    pwdata_nxt   = m_wdata[pick];
                    psel_nxt     = 1'b1;
                    pen_nxt      = 1'b0;
                    gnt_nxt      = '0;
                    gnt_nxt[pick] = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                pen_nxt   = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                // pready on the final allowed cycle still counts as a normal finish.
                if (apb_pready) begin
                    fin     = 1'b1;
                    fin_err = apb_pslverr;
                end else if (tmo_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    fin_tmo = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RECOVER: begin
                gnt_nxt   = '0;
                err_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (fin) begin
            state_nxt     = RECOVER;
            psel_nxt      = 1'b0;
            pen_nxt       = 1'b0;
            done_nxt[win] = 1'b1;
            err_nxt[win]  = fin_err;
            tmo_nxt       = fin_tmo;
            // Writes never disturb the requester's held read data.
            if (!pwrite_q)
                rdata_nxt[win] = fin_err ? '0 : apb_prdata;
        end
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            state    <= IDLE;
            last     <= 1'b1;
            win      <= 1'b0;
            cnt      <= '0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            win      <= win_nxt;
            cnt      <= cnt_nxt;
            psel_q   <= psel_nxt;
            pen_q    <= pen_nxt;
            pwrite_q <= pwrite_nxt;
            paddr_q  <= paddr_nxt;
            pwdata_q <= pwdata_nxt;
            gnt_q    <= gnt_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
            rdata_q  <= rdata_nxt;
            tmo_q    <= tmo_nxt;
        end
    end

    assign apb_psel    = psel_q;
    assign apb_penable = pen_q;
    assign apb_pwrite  = pwrite_q;
    assign apb_paddr   = paddr_q;
    assign apb_pwdata  = pwdata_q;
    assign timeout_evt = tmo_q;
    assign m0_gnt      = gnt_q[0];
    assign m1_gnt      = gnt_q[1];
    assign m0_done     = done_q[0];
    assign m1_done     = done_q[1];
    assign m0_err      = err_q[0];
    assign m1_err      = err_q[1];
    assign m0_rdata    = rdata_q[0];
    assign m1_rdata    = rdata_q[1];

endmodule

// File: tb/tb_apb_share_arbiter.sv
// Bench for apb_share_arbiter (TIMEOUT = 4). A transaction-level model
// predicts, from the moment a request is sampled, the winner, the SETUP /
// ACCESS / RECOVER window, error, read data and timeout of each transfer, and
// doubles as the APB slave. Directed table rows, a round-robin contest, a
// mid-transfer reset and a random traffic phase are run on top of it.

module tb_apb_share_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [1:0]    req;
    logic [1:0]    wr;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd   [2];
    logic          gnt0, gnt1, done0, done1, err0, err1;
    logic [DW-1:0] rd0, rd1;
    logic          psel, pen, pwrite, tmo;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    apb_share_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .apb_pclk(clk), .apb_prstn(rstn),
        .m0_req(req[0]), .m0_addr(addr[0]), .m0_write(wr[0]), .m0_wdata(wd[0]),
        .m0_gnt(gnt0), .m0_done(done0), .m0_err(err0), .m0_rdata(rd0),
        .m1_req(req[1]), .m1_addr(addr[1]), .m1_write(wr[1]), .m1_wdata(wd[1]),
        .m1_gnt(gnt1), .m1_done(done1), .m1_err(err1), .m1_rdata(rd1),
        .apb_psel(psel), .apb_penable(pen), .apb_pwrite(pwrite),
        .apb_paddr(paddr), .apb_pwdata(pwdata), .apb_prdata(prdata),
        .apb_pready(pready), .apb_pslverr(pslverr), .timeout_evt(tmo)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // ---------------- reference model state ----------------
    logic [1:0]    s_req, s_wr;
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_wd   [2];
    logic [DW-1:0] m_rd   [2];
    bit            m_last, act;
    int            t_setup, t_done, free_at, t_ws;
    bit            t_win, t_write, t_slv_err, t_ready, t_err_exp, t_tmo;
    logic [DW-1:0] t_prd;
    bit            rand_slave;
    int            cfg_ws;
    bit            cfg_err;
    logic [DW-1:0] cfg_rd;

    // One clock: snapshot inputs at the edge the DUT samples them, then at the
    // falling edge check outputs and drive the slave response for this cycle.
    task automatic step();
        logic [6:0] exp_ctl;
        logic [1:0] exp_err;
        @(posedge clk);
        s_req  = req;
        s_wr   = wr;
        s_addr = addr;
        s_wd   = wd;
        @(negedge clk);
        cyc++;
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        if (!rstn) begin
            act     = 1'b0;
            m_last  = 1'b1;
            m_rd[0] = '0;
            m_rd[1] = '0;
            free_at = cyc + 1;
            chk("rst_ctl", 64'({psel, pen, gnt1, gnt0, done1, done0, tmo}), 64'(0));
            chk("rst_err", 64'({err1, err0}), 64'(0));
            chk("rst_rdata", {rd1, rd0}, 64'(0));
            chk("rst_bus", 64'({pwrite, paddr}), 64'(0));
            chk("rst_pwdata", 64'(pwdata), 64'(0));
            return;
        end
        if (!act && cyc >= free_at && s_req != 2'b00) begin
            act     = 1'b1;
            t_setup = cyc;
            t_win   = (s_req == 2'b11) ? !m_last : s_req[1];
            m_last  = t_win;
            t_write = s_wr[t_win];
            if (rand_slave) begin
                t_ws      = $urandom_range(0, 5);
                t_slv_err = ($urandom_range(0, 3) == 0);
                t_prd     = $urandom;
            end else begin
                t_ws      = cfg_ws;
                t_slv_err = cfg_err;
                t_prd     = cfg_rd;
            end
            t_ready   = (t_ws < TO);
            t_done    = t_setup + 1 + (t_ready ? t_ws + 1 : TO);
            t_err_exp = t_ready ? t_slv_err : 1'b1;
            t_tmo     = !t_ready;
            chk("setup_paddr", 64'(paddr), 64'(s_addr[t_win]));
            chk("setup_pwrite", 64'(pwrite), 64'(t_write));
            chk("setup_pwdata", 64'(pwdata), 64'(s_wd[t_win]));
        end
        // {psel, penable, gnt1, gnt0, done1, done0, timeout_evt}
        exp_ctl = '0;
        if (act) begin
            exp_ctl[6]         = (cyc < t_done);
            exp_ctl[5]         = (cyc > t_setup) && (cyc < t_done);
            exp_ctl[3 + t_win] = 1'b1;
            exp_ctl[1 + t_win] = (cyc == t_done);
            exp_ctl[0]         = (cyc == t_done) && t_tmo;
        end
        chk("ctl", 64'({psel, pen, gnt1, gnt0, done1, done0, tmo}), 64'(exp_ctl));
        if (act && cyc == t_done) begin
            exp_err        = '0;
            exp_err[t_win] = t_err_exp;
            chk("done_err", 64'({err1, err0}), 64'(exp_err));
            if (!t_write) m_rd[t_win] = t_err_exp ? '0 : t_prd;
            act     = 1'b0;
            free_at = cyc + 2;
        end
        chk("rdata", {rd1, rd0}, {m_rd[1], m_rd[0]});
        if (act && t_ready && cyc == t_setup + 1 + t_ws) begin
            pready  = 1'b1;
            pslverr = t_slv_err;
            prdata  = t_prd;
        end
    endtask

    task automatic new_req(input int i);
        req[i]  = 1'b1;
        wr[i]   = 1'($urandom_range(0, 1));
        addr[i] = $urandom;
        wd[i]   = $urandom;
    endtask

    typedef struct {
        bit          who;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ws;       // wait states before pready; >= TO never readies
        bit          slverr;
        logic [31:0] prd;
        int          exp_lat;  // cycles from request sample edge to done
        bit          exp_err;
        logic [31:0] exp_rd;
        bit          exp_tmo;
    } vec_t;

    vec_t tbl [9];
    vec_t v;
    int   c0;
    bit   got;
    int   order [$];
    int   prst  [$];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         0, 1'b0, 32'hA5A5_0001, 3, 1'b0, 32'hA5A5_0001, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_2004, 32'h0000_0022, 3, 1'b1, 32'h1111_1111, 6, 1'b1, 32'h0,           1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'h0000_3008, 32'h0,         9, 1'b0, 32'hFFFF_FFFF, 6, 1'b1, 32'h0,           1'b1};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_400C, 32'h0,         0, 1'b0, 32'h1234_5678, 3, 1'b0, 32'h1234_5678, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0000_5010, 32'h0,         3, 1'b0, 32'hCAFE_F00D, 6, 1'b0, 32'hCAFE_F00D, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h0000_6014, 32'h0000_0011, 1, 1'b0, 32'h2222_2222, 4, 1'b0, 32'hCAFE_F00D, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_7018, 32'h0,         2, 1'b1, 32'h0000_DEAD, 5, 1'b1, 32'h0,           1'b0};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_801C, 32'h0,         1, 1'b0, 32'h0BAD_F00D, 4, 1'b0, 32'h0BAD_F00D, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 32'h0000_9020, 32'h0000_0033, 0, 1'b0, 32'h3333_3333, 3, 1'b0, 32'h0BAD_F00D, 1'b0};

        rstn = 1'b0; req = '0; wr = '0;
        addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        act = 1'b0; m_last = 1'b1; free_at = 0; rand_slave = 1'b0;
        m_rd[0] = '0; m_rd[1] = '0;
        cfg_ws = 0; cfg_err = 1'b0; cfg_rd = '0;

        step();
        step();
        rstn = 1'b1;
        step();

        // ---- directed single transfers ----
        for (int i = 0; i < 9; i++) begin
            v = tbl[i];
            cfg_ws = v.ws; cfg_err = v.slverr; cfg_rd = v.prd;
            req[v.who] = 1'b1; wr[v.who] = v.write; addr[v.who] = v.addr; wd[v.who] = v.wdata;
            c0 = cyc;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                step();
                got = v.who ? done1 : done0;
            end
            chk("vec_latency", 64'(cyc - c0), 64'(v.exp_lat));
            chk("vec_err", 64'(v.who ? err1 : err0), 64'(v.exp_err));
            chk("vec_rdata", 64'(v.who ? rd1 : rd0), 64'(v.exp_rd));
            chk("vec_timeout_evt", 64'(tmo), 64'(v.exp_tmo));
            req[v.who] = 1'b0;
            step();
            step();
        end

        // ---- simultaneous writes, repeated: grants alternate ----
        cfg_ws = 0; cfg_err = 1'b0;
        for (int r = 0; r < 3; r++) begin
            req = 2'b11; wr = 2'b11;
            addr[0] = 32'h100 + r; addr[1] = 32'h200 + r;
            wd[0] = 32'h11; wd[1] = 32'h22;
            for (int k = 0; k < 40 && req != 2'b00; k++) begin
                step();
                if (done0) begin order.push_back(0); req[0] = 1'b0; end
                if (done1) begin order.push_back(1); req[1] = 1'b0; end
            end
            req = 2'b00;
            step();
        end
        chk("rr_count", 64'(order.size()), 64'(6));
        foreach (order[k]) chk("rr_order", 64'(order[k]), 64'(k % 2));

        // ---- reset while a transfer sits in ACCESS ----
        cfg_ws = 9;
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'hABC0;
        for (int k = 0; k < 10 && !pen; k++) step();
        step();
        #2 rstn = 1'b0;
        #1 chk("async_rst", 64'({psel, pen, gnt1, gnt0, done1, done0}), 64'(0));
        req = 2'b00;
        step();
        rstn = 1'b1;
        cfg_ws = 0; cfg_rd = 32'h5555_AAAA;
        req = 2'b11; wr = 2'b00; addr[0] = 32'h10; addr[1] = 32'h20;
        for (int k = 0; k < 30 && req != 2'b00; k++) begin
            step();
            if (done0) begin prst.push_back(0); req[0] = 1'b0; end
            if (done1) begin prst.push_back(1); req[1] = 1'b0; end
        end
        chk("post_rst_count", 64'(prst.size()), 64'(2));
        if (prst.size() > 0) chk("post_rst_first", 64'(prst[0]), 64'(0));
        req = 2'b00;
        step();

        // ---- random traffic against the model ----
        rand_slave = 1'b1;
        for (int n = 0; n < 600; n++) begin
            step();
            if (req[0]) begin
                if (done0) begin
                    if ($urandom_range(0, 1) == 1) new_req(0);
                    else req[0] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) new_req(0);
            if (req[1]) begin
                if (done1) begin
                    if ($urandom_range(0, 1) == 1) new_req(1);
                    else req[1] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) new_req(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
